// File: rtl/meta_arbiter.sv
// meta_arbiter
//   Arbitrates two read requesters and one loader write port onto a single-port
//   metadata RAM. Writes normally win. A read is forced through after WR_MAX
//   back-to-back write grants. Two pending reads alternate round-robin. Only
//   one transaction is in flight at a time, and every output is registered.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rdN_ren / rdN_raddr   requester N read request (level) and word address
//   rdN_rdata             requester N read data, held between responses
//   rdN_rvalid            one-cycle response pulse
//   rdN_rerr              out-of-range flag, only ever high with rdN_rvalid
//   wr_en/wr_addr/wr_data loader write request (level), address and data
//   wr_ack                one-cycle write-accepted pulse
//   mem_en/mem_we         RAM enable and write enable
//   mem_addr/mem_wdata    RAM address and write data
//   mem_rdata             RAM read data, valid MEM_LAT cycles after a read enable
module meta_arbiter #(
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 1,
  parameter int WR_MAX  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd0_ren,
  input  logic [31:0]              rd0_raddr,
  output logic [31:0]              rd0_rdata,
  output logic                     rd0_rvalid,
  output logic                     rd0_rerr,
  input  logic                     rd1_ren,
  input  logic [31:0]              rd1_raddr,
  output logic [31:0]              rd1_rdata,
  output logic                     rd1_rvalid,
  output logic                     rd1_rerr,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data,
  output logic                     wr_ack,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          SW      = $clog2(WR_MAX + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, WRITE} state_t;

  state_t        state;
  logic          rr_last;
  logic [SW-1:0] wr_streak;
  logic          gnt_sel;
  logic          gnt_oor;
  logic [1:0]    wait_cnt;

  logic          rd_pend;
  logic          wr_win;
  logic          rd_sel;
  logic [31:0]   rd_addr_sel;
  logic          rd_in_range;
  logic          wr_in_range;

  // Grant decision, only acted on in IDLE. A saturated write streak yields
  // to any pending read so the readers cannot be starved by the loader.
  always_comb begin
    rd_pend     = rd0_ren | rd1_ren;
    wr_win      = wr_en && !(rd_pend && (wr_streak == SW'(WR_MAX)));
    if (rd0_ren && rd1_ren) begin
      rd_sel = ~rr_last;
    end else begin
      rd_sel = rd1_ren;
    end
    rd_addr_sel = rd_sel ? rd1_raddr : rd0_raddr;
    rd_in_range = (rd_addr_sel < DEPTH_W);
    wr_in_range = (wr_addr < DEPTH_W);
  end

  // Main FSM. RAM controls are loaded on the edge leaving IDLE so they are
  // already valid in the ISSUE/WRITE cycle. mem_addr itself acts as the
  // latched read address for the rest of the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      wr_streak  <= '0;
      gnt_sel    <= 1'b0;
      gnt_oor    <= 1'b0;
      wait_cnt   <= '0;
      rd0_rdata  <= '0;
      rd0_rvalid <= 1'b0;
      rd0_rerr   <= 1'b0;
      rd1_rdata  <= '0;
      rd1_rvalid <= 1'b0;
      rd1_rerr   <= 1'b0;
      wr_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_win) begin
            state     <= WRITE;
            wr_ack    <= 1'b1;
            mem_en    <= wr_in_range;
            mem_we    <= wr_in_range;
            mem_addr  <= wr_addr[AW-1:0];
            mem_wdata <= wr_data;
            if (wr_streak != SW'(WR_MAX)) begin
              wr_streak <= wr_streak + SW'(1);
            end
          end else if (rd_pend) begin
            state     <= ISSUE;
            gnt_sel   <= rd_sel;
            rr_last   <= rd_sel;
            wr_streak <= '0;
            gnt_oor   <= !rd_in_range;
            mem_en    <= rd_in_range;
            mem_we    <= 1'b0;
            mem_addr  <= rd_addr_sel[AW-1:0];
          end
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= 2'(MEM_LAT - 1);
          state    <= WAIT;
        end
        // Out-of-range reads still spend the full latency here so both
        // kinds of response arrive on the same cycle.
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= RESP;
            if (gnt_sel) begin
              rd1_rvalid <= 1'b1;
              rd1_rerr   <= gnt_oor;
              rd1_rdata  <= gnt_oor ? 32'd0 : mem_rdata;
            end else begin
              rd0_rvalid <= 1'b1;
              rd0_rerr   <= gnt_oor;
              rd0_rdata  <= gnt_oor ? 32'd0 : mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          rd0_rvalid <= 1'b0;
          rd0_rerr   <= 1'b0;
          rd1_rvalid <= 1'b0;
          rd1_rerr   <= 1'b0;
          state      <= IDLE;
        end
        WRITE: begin
          wr_ack <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meta_arbiter.sv
// tb_meta_arbiter
//   Directed testbench for meta_arbiter at default parameters (DEPTH=1024,
//   MEM_LAT=1, WR_MAX=4). A behavioural one-cycle-latency RAM sits on the
//   memory port. Cycle numbering: inputs are driven and outputs sampled 1 time
//   unit after each rising edge, and "cycle 0" is the cycle in which a request
//   is first presented.
module tb_meta_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd0_ren = 1'b0;
  logic [31:0] rd0_raddr = '0;
  logic [31:0] rd0_rdata;
  logic        rd0_rvalid;
  logic        rd0_rerr;
  logic        rd1_ren = 1'b0;
  logic [31:0] rd1_raddr = '0;
  logic [31:0] rd1_rdata;
  logic        rd1_rvalid;
  logic        rd1_rerr;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  meta_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd0_ren    (rd0_ren),
    .rd0_raddr  (rd0_raddr),
    .rd0_rdata  (rd0_rdata),
    .rd0_rvalid (rd0_rvalid),
    .rd0_rerr   (rd0_rerr),
    .rd1_ren    (rd1_ren),
    .rd1_raddr  (rd1_raddr),
    .rd1_rdata  (rd1_rdata),
    .rd1_rvalid (rd1_rvalid),
    .rd1_rerr   (rd1_rerr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // RAM stub: unwritten words read back a fixed pattern, word 5 is 0xDEADBEEF.
  logic [31:0]   ram [0:1023];
  logic [1023:0] wmask = '0;

  function automatic logic [31:0] ram_init(input logic [9:0] a);
    if (a == 10'd5) return 32'hDEADBEEF;
    return 32'h1100_0000 + {22'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        wmask[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wmask[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
      end
    end
  end

  function automatic logic [112:0] all_outputs();
    return {rd0_rdata, rd0_rvalid, rd0_rerr, rd1_rdata, rd1_rvalid, rd1_rerr,
            wr_ack, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rd0_ren = 1'b0;
    rd1_ren = 1'b0;
    wr_en   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int bad;
    step();
    step();
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", all_outputs());
    end
    rst_n   = 1'b1;
    step();
    wr_en   = 1'b1;
    wr_addr = 32'd3;
    wr_data = 32'hA5A5A5A5;
    step();
    checks++;
    if ({wr_ack, mem_en, mem_we} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_pre_write: got %b, expected 111", {wr_ack, mem_en, mem_we});
    end
    rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async_clear: got %h, expected 0", all_outputs());
    end
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (wr_ack || mem_en || rd0_rvalid || rd1_rvalid) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_activity: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_single_read();
    int rv_cnt, rv_cycle, bad_en, rd1_seen;
    logic [31:0] rv_data;
    rv_cnt = 0; rv_cycle = -1; bad_en = 0; rd1_seen = 0; rv_data = '0;
    do_reset();
    rd0_ren   = 1'b1;
    rd0_raddr = 32'd5;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
          errors++;
          $display("[TB] FAIL read_issue: got en=%b we=%b addr=%0d, expected en=1 we=0 addr=5",
                   mem_en, mem_we, mem_addr);
        end
      end else if (mem_en) begin
        bad_en++;
      end
      if (rd0_rvalid) begin
        rv_cnt++;
        rv_cycle = c;
        rv_data  = rd0_rdata;
        rd0_ren  = 1'b0;
      end
      if (rd1_rvalid) rd1_seen++;
      step();
    end
    checks++;
    if (rv_cnt !== 1 || rv_cycle !== 3) begin
      errors++;
      $display("[TB] FAIL read_rvalid_timing: got %0d pulses at cycle %0d, expected 1 at cycle 3",
               rv_cnt, rv_cycle);
    end
    checks++;
    if (rv_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL read_data: got %h, expected deadbeef", rv_data);
    end
    checks++;
    if (rd1_seen !== 0 || bad_en !== 0) begin
      errors++;
      $display("[TB] FAIL read_side_effects: got rd1_rvalid=%0d stray_en=%0d, expected 0 0",
               rd1_seen, bad_en);
    end
    checks++;
    if ({rd0_rdata, rd0_rvalid, rd0_rerr} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL read_hold: got %h v=%b e=%b, expected deadbeef v=0 e=0",
               rd0_rdata, rd0_rvalid, rd0_rerr);
    end
  endtask

  task automatic test_tie();
    int who [4];
    int when [4];
    logic [31:0] dat [4];
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      who[i] = -1; when[i] = -1; dat[i] = '0;
    end
    do_reset();
    rd0_ren = 1'b1; rd0_raddr = 32'd1;
    rd1_ren = 1'b1; rd1_raddr = 32'd2;
    for (int c = 0; c < 17; c++) begin
      if (n < 4 && rd0_rvalid) begin
        who[n] = 0; when[n] = c; dat[n] = rd0_rdata; n++;
      end
      if (n < 4 && rd1_rvalid) begin
        who[n] = 1; when[n] = c; dat[n] = rd1_rdata; n++;
      end
      step();
    end
    rd0_ren = 1'b0;
    rd1_ren = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("[TB] FAIL tie_count: got %0d responses, expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (who[i] !== (i % 2) || when[i] !== 3 + 4 * i) begin
        errors++;
        $display("[TB] FAIL tie_order[%0d]: got rd%0d at cycle %0d, expected rd%0d at cycle %0d",
                 i, who[i], when[i], i % 2, 3 + 4 * i);
      end
      checks++;
      if (dat[i] !== ((i % 2 == 0) ? 32'h11000001 : 32'h11000002)) begin
        errors++;
        $display("[TB] FAIL tie_data[%0d]: got %h, expected %h", i, dat[i],
                 (i % 2 == 0) ? 32'h11000001 : 32'h11000002);
      end
    end
  endtask

  task automatic test_write_starvation();
    int acks [8];
    int n_ack, rv_cycle;
    n_ack = 0; rv_cycle = -1;
    for (int i = 0; i < 8; i++) acks[i] = -1;
    do_reset();
    wr_en = 1'b1; wr_addr = 32'd100; wr_data = 32'hCAFE0000;
    rd0_ren = 1'b1; rd0_raddr = 32'd5;
    for (int c = 0; c < 15; c++) begin
      if (c == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd100, 32'hCAFE0000}) begin
          errors++;
          $display("[TB] FAIL write_drive: got en=%b we=%b addr=%0d data=%h, expected 1 1 100 cafe0000",
                   mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 9) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
          errors++;
          $display("[TB] FAIL starve_read_issue: got en=%b we=%b addr=%0d, expected 1 0 5",
                   mem_en, mem_we, mem_addr);
        end
      end
      if (wr_ack && n_ack < 8) begin
        acks[n_ack] = c;
        n_ack++;
      end
      if (rd0_rvalid) begin
        rv_cycle = c;
        rd0_ren  = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    checks++;
    if (n_ack !== 5 || acks[0] !== 1 || acks[1] !== 3 || acks[2] !== 5 || acks[3] !== 7) begin
      errors++;
      $display("[TB] FAIL starve_write_acks: got %0d acks first at %0d,%0d,%0d,%0d, expected 5 acks at 1,3,5,7",
               n_ack, acks[0], acks[1], acks[2], acks[3]);
    end
    checks++;
    if (rv_cycle !== 11) begin
      errors++;
      $display("[TB] FAIL starve_read_slot: got rd0_rvalid at cycle %0d, expected 11", rv_cycle);
    end
    checks++;
    if (acks[4] !== 13) begin
      errors++;
      $display("[TB] FAIL starve_write_resume: got ack at cycle %0d, expected 13", acks[4]);
    end
  endtask

  task automatic test_out_of_range();
    int en_seen;
    en_seen = 0;
    do_reset();
    rd1_ren = 1'b1; rd1_raddr = 32'd2;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rd1_ren = 1'b0;
      step();
    end
    checks++;
    if (rd1_rdata !== 32'h11000002) begin
      errors++;
      $display("[TB] FAIL oor_preload: got %h, expected 11000002", rd1_rdata);
    end
    rd1_ren = 1'b1; rd1_raddr = 32'd1024;
    for (int c = 0; c < 5; c++) begin
      if (mem_en) en_seen++;
      if (c == 3) begin
        checks++;
        if ({rd1_rvalid, rd1_rerr, rd1_rdata} !== {1'b1, 1'b1, 32'd0}) begin
          errors++;
          $display("[TB] FAIL oor_read_resp: got v=%b e=%b data=%h, expected v=1 e=1 data=0",
                   rd1_rvalid, rd1_rerr, rd1_rdata);
        end
        rd1_ren = 1'b0;
      end
      if (c == 4) begin
        checks++;
        if ({rd1_rvalid, rd1_rerr} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL oor_rerr_clear: got v=%b e=%b, expected 0 0", rd1_rvalid, rd1_rerr);
        end
      end
      step();
    end
    checks++;
    if (en_seen !== 0) begin
      errors++;
      $display("[TB] FAIL oor_read_no_mem: got %0d enable cycles, expected 0", en_seen);
    end
    wr_en = 1'b1; wr_addr = 32'd2000; wr_data = 32'h00000055;
    step();
    checks++;
    if ({wr_ack, mem_en, mem_we} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL oor_write: got ack=%b en=%b we=%b, expected ack=1 en=0 we=0",
               wr_ack, mem_en, mem_we);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_write_pulse: got ack=%b, expected 0", wr_ack);
    end
  endtask

  task automatic test_write_then_read();
    do_reset();
    wr_en = 1'b1; wr_addr = 32'd7; wr_data = 32'h12345678;
    step();
    checks++;
    if ({wr_ack, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd7, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL wtr_write: got ack=%b en=%b we=%b addr=%0d data=%h, expected 1 1 1 7 12345678",
               wr_ack, mem_en, mem_we, mem_addr, mem_wdata);
    end
    wr_en = 1'b0;
    step();
    rd0_ren = 1'b1; rd0_raddr = 32'd7;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if ({rd0_rvalid, rd0_rerr, rd0_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL wtr_read: got v=%b e=%b data=%h, expected v=1 e=0 data=12345678",
               rd0_rvalid, rd0_rerr, rd0_rdata);
    end
    rd0_ren = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    int bad;
    do_reset();
    rd0_ren = 1'b1; rd0_raddr = 32'd1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rd0_ren = 1'b0;
      step();
    end
    rd0_ren = 1'b1; rd0_raddr = 32'd5;
    step();
    step();
    rst_n   = 1'b0;
    rd0_ren = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("[TB] FAIL wait_reset_clear: got %h, expected 0", all_outputs());
    end
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd0_rvalid || rd1_rvalid || mem_en || wr_ack) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL wait_reset_discard: got %0d active cycles, expected 0", bad);
    end
    rd1_ren = 1'b1; rd1_raddr = 32'd2;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if ({rd1_rvalid, rd1_rdata} !== {1'b1, 32'h11000002}) begin
      errors++;
      $display("[TB] FAIL wait_reset_recover: got v=%b data=%h, expected v=1 data=11000002",
               rd1_rvalid, rd1_rdata);
    end
    rd1_ren = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_starvation();
    test_out_of_range();
    test_write_then_read();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
